// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NREQ simple-command requesters.
// One transaction is in flight at a time; the granted requester receives a one-cycle response pulse.
module axil_req_arbiter #(
   parameter int NREQ   = 4,
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0]            req_wr,
   input  logic [NREQ*AWIDTH-1:0]     req_addr,
   input  logic [NREQ*DWIDTH-1:0]     req_wdata,
   input  logic [NREQ*DWIDTH/8-1:0]   req_wstrb,
   output logic [NREQ-1:0]            resp_valid,
   output logic [DWIDTH-1:0]          resp_rdata,
   output logic [1:0]                 resp_resp,
   output logic                       resp_err,
   output logic [AWIDTH-1:0]          awaddr,
   output logic                       awvalid,
   input  logic                       awready,
   output logic [DWIDTH-1:0]          wdata,
   output logic [DWIDTH/8-1:0]        wstrb,
   output logic                       wvalid,
   input  logic                       wready,
   input  logic [1:0]                 bresp,
   input  logic                       bvalid,
   output logic                       bready,
   output logic [AWIDTH-1:0]          araddr,
   output logic                       arvalid,
   input  logic                       arready,
   input  logic [DWIDTH-1:0]          rdata,
   input  logic [1:0]                 rresp,
   input  logic                       rvalid,
   output logic                       rready
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = DWIDTH / 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR_AW = 3'd1;
   localparam logic [2:0] S_WR_B  = 3'd2;
   localparam logic [2:0] S_RD_AR = 3'd3;
   localparam logic [2:0] S_RD_R  = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]        state_q,      state_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [AWIDTH-1:0] addr_q,       addr_d;
   logic [DWIDTH-1:0] wdata_q,      wdata_d;
   logic [SW-1:0]     wstrb_q,      wstrb_d;
   logic [NREQ-1:0]   req_ready_q,  req_ready_d;
   logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
   logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic [1:0]        resp_resp_q,  resp_resp_d;
   logic              resp_err_q,   resp_err_d;
   logic              awvalid_q,    awvalid_d;
   logic              wvalid_q,     wvalid_d;
   logic              bready_q,     bready_d;
   logic              arvalid_q,    arvalid_d;
   logic              rready_q,     rready_d;

   logic              found;
   logic [GW-1:0]     sel;

   // Scan starts just past the previous winner, so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
            found = 1'b1;
            sel   = GW'((int'(last_grant_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      req_ready_d  = '0;
      resp_valid_d = '0;
      resp_rdata_d = resp_rdata_q;
      resp_resp_d  = resp_resp_q;
      resp_err_d   = resp_err_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ready_d[sel] = 1'b1;
               last_grant_d     = sel;
               addr_d           = req_addr[sel*AWIDTH +: AWIDTH];
               wdata_d          = req_wdata[sel*DWIDTH +: DWIDTH];
               wstrb_d          = req_wstrb[sel*SW +: SW];
               if (req_wr[sel]) begin
                  state_d   = S_WR_AW;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_AR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR_AW: begin
            // AW and W complete independently; B is only accepted once both are done.
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_WR_B;
            end
         end
         S_WR_B: begin
            if (bvalid && bready_q) begin
               resp_rdata_d = '0;
               resp_resp_d  = bresp;
               resp_err_d   = (bresp != 2'b00);
               bready_d     = 1'b0;
               state_d      = S_RESP;
            end
         end
         S_RD_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_R;
            end
         end
         S_RD_R: begin
            if (rvalid && rready_q) begin
               resp_rdata_d = rdata;
               resp_resp_d  = rresp;
               resp_err_d   = (rresp != 2'b00);
               rready_d     = 1'b0;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid_d[last_grant_q] = 1'b1;
            state_d                    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         last_grant_q <= GW'(NREQ - 1);
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         req_ready_q  <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_resp_q  <= '0;
         resp_err_q   <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_resp_q  <= resp_resp_d;
         resp_err_q   <= resp_err_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_resp  = resp_resp_q;
   assign resp_err   = resp_err_q;
   assign awaddr     = addr_q;
   assign araddr     = addr_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign awvalid    = awvalid_q;
   assign wvalid     = wvalid_q;
   assign bready     = bready_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: one task per scenario, each checking against hand-computed values.
module tb_axil_req_arbiter;

   logic        aclk;
   logic        aresetn;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  req_wr;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic [3:0]  resp_valid;
   logic [15:0] resp_rdata;
   logic [1:0]  resp_resp;
   logic        resp_err;
   logic [7:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [15:0] wdata;
   logic [1:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [15:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_pass   = 0;

   axil_req_arbiter #(.NREQ(4), .AWIDTH(8), .DWIDTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp), .resp_err(resp_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic apply_reset();
      aresetn = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   // driver tasks
   task automatic set_req(input int i, input logic wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [1:0] s);
      req_wr[i]            = wr;
      req_addr[i*8 +: 8]   = a;
      req_wdata[i*16 +: 16] = d;
      req_wstrb[i*2 +: 2]  = s;
      req_valid[i]         = 1'b1;
   endtask

   task automatic slave_idle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
   endtask

   task automatic slave_auto_write();
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
   endtask

   task automatic wait_ready(output logic [3:0] seen, output bit ok);
      ok = 1'b0;
      seen = '0;
      for (int c = 0; c < 32 && !ok; c++) begin
         tick();
         if (req_ready != 4'b0000) begin
            ok = 1'b1;
            seen = req_ready;
         end
      end
   endtask

   task automatic wait_resp(output logic [3:0] seen, output bit ok);
      ok = 1'b0;
      seen = '0;
      for (int c = 0; c < 32 && !ok; c++) begin
         tick();
         if (resp_valid != 4'b0000) begin
            ok = 1'b1;
            seen = resp_valid;
         end
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({req_ready, resp_valid, resp_rdata, resp_resp, resp_err, awaddr, awvalid, wdata, wstrb,
           wvalid, bready, araddr, arvalid, rready} !== '0)
         $display("FAIL reset_outputs: req_ready=%b resp_valid=%b awvalid=%b wvalid=%b bready=%b arvalid=%b rready=%b required all zero",
                  req_ready, resp_valid, awvalid, wvalid, bready, arvalid, rready);
      else n_pass++;
   endtask

   task automatic test_write_basic();
      set_req(0, 1'b1, 8'h0F, 16'hABAB, 2'b11);
      awready = 1'b1; wready = 1'b1;
      tick();
      n_checks++;
      if ({req_ready, awvalid, wvalid, awaddr, wdata, wstrb} !== {4'b0001, 1'b1, 1'b1, 8'h0F, 16'hABAB, 2'b11})
         $display("FAIL wr_grant: req_ready=%b awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%b required 0001 1 1 0f abab 11",
                  req_ready, awvalid, wvalid, awaddr, wdata, wstrb);
      else n_pass++;
      req_valid[0] = 1'b0;
      tick();
      n_checks++;
      if ({req_ready, awvalid, wvalid, bready} !== {4'b0000, 1'b0, 1'b0, 1'b1})
         $display("FAIL wr_after_hs: req_ready=%b awvalid=%b wvalid=%b bready=%b required 0000 0 0 1",
                  req_ready, awvalid, wvalid, bready);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if ({bready, resp_valid} !== {1'b1, 4'b0000})
            $display("FAIL wr_b_wait: bready=%b resp_valid=%b required 1 0000", bready, resp_valid);
         else n_pass++;
      end
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      n_checks++;
      if ({bready, resp_valid} !== {1'b0, 4'b0000})
         $display("FAIL wr_b_capture: bready=%b resp_valid=%b required 0 0000", bready, resp_valid);
      else n_pass++;
      tick();
      n_checks++;
      if ({resp_valid, resp_err, resp_resp, resp_rdata} !== {4'b0001, 1'b0, 2'b00, 16'h0000})
         $display("FAIL wr_resp: resp_valid=%b err=%b resp=%b rdata=%h required 0001 0 00 0000",
                  resp_valid, resp_err, resp_resp, resp_rdata);
      else n_pass++;
      tick();
      n_checks++;
      if (resp_valid !== 4'b0000) $display("FAIL wr_resp_drop: resp_valid=%b required 0000", resp_valid);
      else n_pass++;
      slave_idle();
   endtask

   task automatic test_read_basic();
      set_req(1, 1'b0, 8'hAA, 16'h0000, 2'b00);
      arready = 1'b1;
      tick();
      n_checks++;
      if ({req_ready, arvalid, araddr, awvalid} !== {4'b0010, 1'b1, 8'hAA, 1'b0})
         $display("FAIL rd_grant: req_ready=%b arvalid=%b araddr=%h awvalid=%b required 0010 1 aa 0",
                  req_ready, arvalid, araddr, awvalid);
      else n_pass++;
      req_valid[1] = 1'b0;
      tick();
      n_checks++;
      if ({arvalid, rready} !== 2'b01) $display("FAIL rd_after_ar: arvalid=%b rready=%b required 0 1", arvalid, rready);
      else n_pass++;
      tick();
      tick();
      rvalid = 1'b1; rdata = 16'h1234; rresp = 2'b00;
      tick();
      rvalid = 1'b0;
      n_checks++;
      if (rready !== 1'b0) $display("FAIL rd_capture: rready=%b required 0", rready);
      else n_pass++;
      tick();
      n_checks++;
      if ({resp_valid, resp_rdata, resp_err} !== {4'b0010, 16'h1234, 1'b0})
         $display("FAIL rd_resp: resp_valid=%b rdata=%h err=%b required 0010 1234 0", resp_valid, resp_rdata, resp_err);
      else n_pass++;
      slave_idle();
   endtask

   task automatic test_round_robin();
      logic [3:0] seen;
      logic [3:0] rseen;
      bit ok;
      bit rok;
      int exp_order [6] = '{0, 1, 2, 3, 0, 3};
      apply_reset();
      slave_auto_write();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 16'(16'h1000 + i), 2'b11);
      for (int t = 0; t < 6; t++) begin
         if (t == 4) begin
            set_req(0, 1'b1, 8'h10, 16'h1000, 2'b11);
            set_req(3, 1'b1, 8'h13, 16'h1003, 2'b11);
         end
         wait_ready(seen, ok);
         n_checks++;
         if (!ok || seen !== (4'b0001 << exp_order[t]) || awaddr !== 8'(8'h10 + exp_order[t]))
            $display("FAIL rr_grant_%0d: req_ready=%b awaddr=%h timeout=%0d required %b %h",
                     t, seen, awaddr, !ok, 4'b0001 << exp_order[t], 8'(8'h10 + exp_order[t]));
         else n_pass++;
         req_valid = req_valid & ~seen;
         wait_resp(rseen, rok);
         n_checks++;
         if (!rok || rseen !== (4'b0001 << exp_order[t]))
            $display("FAIL rr_resp_%0d: resp_valid=%b timeout=%0d required %b", t, rseen, !rok, 4'b0001 << exp_order[t]);
         else n_pass++;
      end
      slave_idle();
   endtask

   task automatic test_aw_stall();
      bit bad_aw = 1'b0;
      bit bad_w = 1'b0;
      bit bad_b = 1'b0;
      set_req(2, 1'b1, 8'h5C, 16'hC0DE, 2'b01);
      awready = 1'b0; wready = 1'b1;
      bvalid = 1'b1; bresp = 2'b00;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0) req_valid[2] = 1'b0;
         if (awvalid !== 1'b1 || awaddr !== 8'h5C) bad_aw = 1'b1;
         if (c > 0 && wvalid !== 1'b0) bad_w = 1'b1;
         if (bready !== 1'b0) bad_b = 1'b1;
      end
      n_checks++;
      if (bad_aw) $display("FAIL stall_aw_stable: awvalid=%b awaddr=%h required 1 5c for 4 cycles", awvalid, awaddr);
      else n_pass++;
      n_checks++;
      if (bad_w) $display("FAIL stall_w_drop: wvalid=%b required 0 after its handshake", wvalid);
      else n_pass++;
      n_checks++;
      if (bad_b) $display("FAIL stall_bready_early: bready=%b required 0 before AW handshake", bready);
      else n_pass++;
      awready = 1'b1;
      tick();
      n_checks++;
      if ({awvalid, bready, resp_valid} !== {1'b0, 1'b1, 4'b0000})
         $display("FAIL stall_aw_done: awvalid=%b bready=%b resp_valid=%b required 0 1 0000", awvalid, bready, resp_valid);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if ({resp_valid, resp_err} !== {4'b0100, 1'b0})
         $display("FAIL stall_resp: resp_valid=%b err=%b required 0100 0", resp_valid, resp_err);
      else n_pass++;
      slave_idle();
   endtask

   task automatic test_read_error();
      logic [3:0] seen;
      bit ok;
      set_req(3, 1'b0, 8'h55, 16'h0000, 2'b00);
      arready = 1'b1;
      rvalid = 1'b1; rdata = 16'hBEEF; rresp = 2'b10;
      wait_ready(seen, ok);
      req_valid[3] = 1'b0;
      n_checks++;
      if (!ok || seen !== 4'b1000 || araddr !== 8'h55)
         $display("FAIL err_grant: req_ready=%b araddr=%h timeout=%0d required 1000 55", seen, araddr, !ok);
      else n_pass++;
      wait_resp(seen, ok);
      n_checks++;
      if (!ok || {seen, resp_resp, resp_err, resp_rdata} !== {4'b1000, 2'b10, 1'b1, 16'hBEEF})
         $display("FAIL err_resp: resp_valid=%b resp=%b err=%b rdata=%h timeout=%0d required 1000 10 1 beef",
                  seen, resp_resp, resp_err, resp_rdata, !ok);
      else n_pass++;
      slave_idle();
   endtask

   task automatic test_reset_mid();
      logic [3:0] seen;
      bit ok;
      bit stray = 1'b0;
      set_req(0, 1'b0, 8'h33, 16'h0000, 2'b00);
      arready = 1'b1;
      tick();
      req_valid[0] = 1'b0;
      tick();
      n_checks++;
      if (rready !== 1'b1) $display("FAIL mid_rd_r: rready=%b required 1", rready);
      else n_pass++;
      aresetn = 1'b0;
      #1;
      n_checks++;
      if ({rready, resp_valid, arvalid, req_ready} !== '0)
         $display("FAIL mid_async_clear: rready=%b resp_valid=%b arvalid=%b req_ready=%b required all 0",
                  rready, resp_valid, arvalid, req_ready);
      else n_pass++;
      rvalid = 1'b1; rdata = 16'hDEAD;
      tick();
      tick();
      aresetn = 1'b1;
      rvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (resp_valid !== 4'b0000) stray = 1'b1;
      end
      n_checks++;
      if (stray) $display("FAIL mid_no_resp: resp_valid=%b required 0000 after reset", resp_valid);
      else n_pass++;
      slave_auto_write();
      set_req(1, 1'b1, 8'h21, 16'h2121, 2'b11);
      set_req(2, 1'b1, 8'h22, 16'h2222, 2'b11);
      wait_ready(seen, ok);
      req_valid = req_valid & ~seen;
      n_checks++;
      if (!ok || seen !== 4'b0010) $display("FAIL mid_first_grant: req_ready=%b timeout=%0d required 0010", seen, !ok);
      else n_pass++;
      wait_resp(seen, ok);
      wait_ready(seen, ok);
      req_valid = req_valid & ~seen;
      n_checks++;
      if (!ok || seen !== 4'b0100) $display("FAIL mid_second_grant: req_ready=%b timeout=%0d required 0100", seen, !ok);
      else n_pass++;
      wait_resp(seen, ok);
      slave_idle();
   endtask

   initial begin
      aresetn = 1'b0;
      req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      slave_idle();
      tick();
      test_reset();
      aresetn = 1'b1;
      tick();
      test_write_basic();
      test_read_basic();
      test_round_robin();
      test_aw_stall();
      test_read_error();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
